mux3_bus_arbiter: RTL
=====================

Name: mux3_bus_arbiter

Overview:
- Round-robin arbiter that shares one memory/bus port between three requesters: 0 = instruction fetch, 1 = load/store, 2 = debug/DMA.
- Drives the select of the existing 3:1 width-parameterised bus mux and holds each grant for a whole multi-beat burst.
- Sits between the core's memory-side requesters and the single external bus interface.

Parameters:
- TIMEOUT, 16: maximum cycles a grant may be held before forced release. Used only with MUX3_ARB_TIMEOUT_EN.
- TO_W, 5: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  3  per-requester request; held high for the whole burst
- last  input  3  per-requester flag: current beat is the final beat of the burst
- bus_ready  input  1  bus accepts the current beat this cycle
- grant  output  3  one-hot registered grant; 000 when idle
- sel  output  2  mux select: 00/01/10 = requester 0/1/2; never 11
- bus_valid  output  1  req[g] & busy, where g is the granted index
- busy  output  1  a grant is active
- timeout  output  1  one-cycle pulse on forced release (tied 0 when feature is off)

Behaviour:
- State machine: IDLE, BUSY. Registers: grant, sel, ptr[1:0] (last granted index), busy.
- Reset values: grant=000, sel=00, busy=0, bus_valid=0, timeout=0, ptr=2, so requester 0 wins first. Reset mid-burst aborts the burst immediately; no beat is completed.
- Arbitration point: any cycle that is IDLE, or BUSY with a releasing event.
  - Search order is ptr+1, ptr+2, ptr (mod 3); the first requester with req high wins.
  - The new grant, sel and ptr take effect on the next clock edge (1-cycle grant latency from req).
  - With no request, go to IDLE with grant=000; sel keeps its last value.
- Beat: bus_valid & bus_ready.
- Releasing events in BUSY:
  - (a) beat with last[g]=1: burst complete.
  - (b) req[g]=0 while granted: abandon.
  - (c) timeout, when the feature is enabled.
- Back-to-back: if another request is pending at a releasing event, the grant switches directly next cycle with no IDLE bubble.
- If the released requester is the only one still requesting, it may be re-granted, but only after the others in the search order.
- bus_ready low: the grant is held and no state changes (except the timeout counter).
- Requests arriving while BUSY are ignored until the next arbitration point. There is no preemption.
- Arbitration order is computed fresh from req; there is no queueing.
- ptr is updated only when a new grant is issued.
- sel always equals the encoded index of the granted requester while busy. The illegal value 11 is never produced.
- Fairness: with all three requesting continuously, grants cycle 0,1,2,0,...

Optional Feature:
- Macro: MUX3_ARB_TIMEOUT_EN.
- When defined:
  - TO_W-bit counter cleared on each new grant; increments every BUSY cycle.
  - When count reaches TIMEOUT-1 without release: forced release at that edge, timeout pulses high for 1 cycle, and arbitration proceeds as a normal releasing event.
- When undefined: no counter; timeout is tied to 0; a grant is held indefinitely until last or req drop.

Test Plan:
- Reset: hold reset 2 cycles with req=111 -> grant=000, sel=00, busy=0, bus_valid=0; after release, grant=001 one cycle later.
- Single burst: req=010, bus_ready=1, last[1] high on the 4th beat -> grant=010 and sel=01 for 4 cycles, then grant=000 and busy=0.
- Fairness: req=111 held, every burst 1 beat, bus_ready=1 -> grant sequence 001,010,100,001,010,100 with no idle cycles.
- Stall: requester 2 granted, bus_ready=0 for 5 cycles, then beat with last -> grant=100 and sel=10 held the whole time; release exactly on the last beat.
- Abandon and reset: requester 1 drops req mid-burst while req[0]=1 -> grant=001 next cycle. Separately, assert reset mid-burst -> all outputs return to reset values next cycle.
- Timeout (MUX3_ARB_TIMEOUT_EN, TIMEOUT=16): requester 0 holds req without last, bus_ready=1, req[2]=1 -> timeout pulses after 16 BUSY cycles and grant=100 next. Without the macro: no release, timeout stays 0.

Source files
------------

// File: rtl/mux3_bus_arbiter_if.sv
// Bus-side handshake bundle between the three memory requesters and the arbiter.
// master = requester/bus side, slave = arbiter.
interface mux3_bus_arbiter_if;
    logic [2:0] req;
    logic [2:0] last;
    logic       bus_ready;
    logic [2:0] grant;
    logic [1:0] sel;
    logic       bus_valid;
    logic       busy;
    logic       timeout;

    modport master (
        output req, last, bus_ready,
        input  grant, sel, bus_valid, busy, timeout
    );

    modport slave (
        input  req, last, bus_ready,
        output grant, sel, bus_valid, busy, timeout
    );
endinterface

// File: rtl/mux3_bus_arbiter.sv
// Round-robin arbiter for the shared 3:1 bus mux; holds each grant for a whole burst.
// Optional forced release after TIMEOUT busy cycles when MUX3_ARB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no grant active, arbitrate every cycle
// BUSY  | grant held until last beat, req drop or timeout
module mux3_bus_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic               clk,
    input  logic               reset,
    mux3_bus_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] grant_q, grant_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;

    logic       busy;
    logic       req_g;
    logic       valid;
    logic       rel_last;
    logic       rel_drop;
    logic       to_hit;
    logic       arb;
    logic       found;
    logic [1:0] win;
    logic [1:0] cand;

    function automatic logic [1:0] inc3(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    assign busy     = (state_q == BUSY);
    assign req_g    = |(bus.req & grant_q);
    assign valid    = busy & req_g;
    assign rel_last = valid & bus.bus_ready & (|(bus.last & grant_q));
    assign rel_drop = busy & ~req_g;
    assign arb      = ~busy | rel_last | rel_drop | to_hit;

`ifdef MUX3_ARB_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    assign to_hit      = busy && (to_cnt_q == TO_W'(TIMEOUT - 1));
    // Only report a forced release when nothing else would have released anyway.
    assign bus.timeout = to_hit & ~rel_last & ~rel_drop;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (arb && found) begin
            to_cnt_d = '0;
        end else if (busy) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic unused_cfg;

    assign to_hit      = 1'b0;
    assign bus.timeout = 1'b0;
    assign unused_cfg  = (TIMEOUT > 0) ^ (TO_W > 0);
`endif

    // Search ptr+1, ptr+2, ptr so the previous owner is considered last.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        cand  = ptr_q;
        for (int k = 0; k < 3; k++) begin
            cand = inc3(cand);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (arb) begin
            if (found) begin
                state_d = BUSY;
                grant_d = 3'b001 << win;
                sel_d   = win;
                ptr_d   = win;
            end else begin
                state_d = IDLE;
                grant_d = 3'b000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 3'b000;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd2;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = busy;
    assign bus.bus_valid = valid;

endmodule
